// File: rtl/muldiv_iter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_iter_pkg : M-extension alucodes, FSM states and op-class helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package muldiv_iter_pkg;

   localparam logic [5:0] ALU_MUL    = 6'd16;
   localparam logic [5:0] ALU_MULH   = 6'd17;
   localparam logic [5:0] ALU_MULHSU = 6'd18;
   localparam logic [5:0] ALU_MULHU  = 6'd19;
   localparam logic [5:0] ALU_DIV    = 6'd20;
   localparam logic [5:0] ALU_DIVU   = 6'd21;
   localparam logic [5:0] ALU_REM    = 6'd22;
   localparam logic [5:0] ALU_REMU   = 6'd23;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic is_mulop(input logic [5:0] code);
      return (code == ALU_MUL) || (code == ALU_MULH) ||
             (code == ALU_MULHSU) || (code == ALU_MULHU);
   endfunction

   function automatic logic is_divop(input logic [5:0] code);
      return (code == ALU_DIV) || (code == ALU_DIVU) ||
             (code == ALU_REM) || (code == ALU_REMU);
   endfunction

   function automatic logic is_remop(input logic [5:0] code);
      return (code == ALU_REM) || (code == ALU_REMU);
   endfunction

   // MUL low half is sign-agnostic, so it is treated as unsigned
   function automatic logic op1_signed(input logic [5:0] code);
      return (code == ALU_MULH) || (code == ALU_MULHSU) ||
             (code == ALU_DIV) || (code == ALU_REM);
   endfunction

   function automatic logic op2_signed(input logic [5:0] code);
      return (code == ALU_MULH) || (code == ALU_DIV) || (code == ALU_REM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_negate : conditional two's-complement of a W-bit value
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_negate #(
   parameter int W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_iter : iterative RV32M/RV64M multiply/divide, one bit per cycle
// Option MULDIV_EARLY_OUT_EN: data-dependent early termination.  Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       alucode,
   input  logic [XLEN-1:0]  op1,
   input  logic [XLEN-1:0]  op2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] out_tag,
   output logic             illegal
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, start_cnt;
   logic [5:0]        op;
   logic              neg_res, neg_rem;
   logic [2*XLEN-1:0] acc, mcand, prod;
   logic [XLEN-1:0]   mplier, rem, dvsr;   // mplier doubles as dividend/quotient shifter
   logic [XLEN-1:0]   mag1, mag2, fast_res, fix_res, quo, rmd, diff, mpl_nx;
   logic [XLEN:0]     rem_sh;
   logic              sgn1, sgn2, accept, fast, q_bit, calc_last;

   assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready && !flush;

   assign sgn1 = op1_signed(alucode) & op1[XLEN-1];
   assign sgn2 = op2_signed(alucode) & op2[XLEN-1];

   muldiv_negate #(.W(XLEN))   u_neg_op1 (.neg(sgn1),    .din(op1),    .dout(mag1));
   muldiv_negate #(.W(XLEN))   u_neg_op2 (.neg(sgn2),    .din(op2),    .dout(mag2));
   muldiv_negate #(.W(2*XLEN)) u_neg_prd (.neg(neg_res), .din(acc),    .dout(prod));
   muldiv_negate #(.W(XLEN))   u_neg_quo (.neg(neg_res), .din(mplier), .dout(quo));
   muldiv_negate #(.W(XLEN))   u_neg_rem (.neg(neg_rem), .din(rem),    .dout(rmd));

   always_comb begin
      fast     = 1'b0;
      fast_res = '0;
      if (!is_mulop(alucode) && !is_divop(alucode)) begin
         fast = 1'b1;
      end else if (is_divop(alucode) && op2 == '0) begin
         fast     = 1'b1;
         fast_res = is_remop(alucode) ? op1 : '1;
      end else if ((alucode == ALU_DIV || alucode == ALU_REM) &&
                   op1 == MIN_INT && op2 == '1) begin
         fast     = 1'b1;
         fast_res = (alucode == ALU_DIV) ? MIN_INT : '0;
      end
   end

   // Restoring divide step: trial subtract on the shifted partial remainder
   assign rem_sh = {rem, mplier[XLEN-1]};
   assign q_bit  = (rem_sh >= {1'b0, dvsr});
   assign diff   = rem_sh[XLEN-1:0] - dvsr;
   assign mpl_nx = is_divop(op) ? {mplier[XLEN-2:0], q_bit} : (mplier >> 1);

`ifdef MULDIV_EARLY_OUT_EN
   function automatic logic [CNT_W-1:0] lead_zeros(input logic [XLEN-1:0] v);
      logic [CNT_W-1:0] n;
      n = CNT_W'(XLEN-1);
      for (int i = 0; i < XLEN; i++)
         if (v[i]) n = CNT_W'(XLEN-1-i);
      return n;
   endfunction

   assign start_cnt = is_divop(alucode) ? lead_zeros(mag1) : '0;
   assign calc_last = (cnt == CNT_W'(XLEN-1)) || (is_mulop(op) && mpl_nx == '0);
`else
   assign start_cnt = '0;
   assign calc_last = (cnt == CNT_W'(XLEN-1));
`endif

   always_comb begin
      fix_res = rmd;
      case (op)
         ALU_MUL:                         fix_res = prod[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_res = prod[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:               fix_res = quo;
         default:                         ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept) state_nx = fast ? ST_DONE : ST_CALC;
         ST_CALC: if (calc_last) state_nx = ST_FIX;
         ST_FIX:  state_nx = ST_DONE;
         ST_DONE: begin
            if (accept)         state_nx = fast ? ST_DONE : ST_CALC;
            else if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (flush) state_nx = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         op      <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         rem     <= '0;
         dvsr    <= '0;
         result  <= '0;
         out_tag <= '0;
         illegal <= 1'b0;
      end else if (accept) begin
         cnt     <= start_cnt;
         op      <= alucode;
         neg_res <= sgn1 ^ sgn2;
         neg_rem <= sgn1;
         acc     <= '0;
         mcand   <= {{XLEN{1'b0}}, mag1};
         mplier  <= is_divop(alucode) ? (mag1 << start_cnt) : mag2;
         rem     <= '0;
         dvsr    <= mag2;
         out_tag <= in_tag;
         illegal <= !is_mulop(alucode) && !is_divop(alucode);
         if (fast) result <= fast_res;
      end else if (state == ST_CALC) begin
         cnt    <= calc_last ? '0 : cnt + 1'b1;
         mplier <= mpl_nx;
         if (is_divop(op)) begin
            rem <= q_bit ? diff : rem_sh[XLEN-1:0];
         end else begin
            acc   <= acc + (mplier[0] ? mcand : '0);
            mcand <= mcand << 1;
         end
      end else if (state == ST_FIX) begin
         result <= fix_res;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_iter : directed vector table plus handshake/flush/reset sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_iter;
   import muldiv_iter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [5:0]  alucode;
   logic [31:0] op1, op2, result;
   logic [4:0]  in_tag, out_tag;

   logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64, illegal64;
   logic [5:0]  alucode64;
   logic [63:0] a64, b64, result64;
   logic [4:0]  tag64, out_tag64;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   muldiv_iter #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alucode(alucode), .op1(op1), .op2(op2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .out_tag(out_tag), .illegal(illegal));

   muldiv_iter #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
      .alucode(alucode64), .op1(a64), .op2(b64), .in_tag(tag64),
      .out_valid(out_valid64), .out_ready(out_ready64), .result(result64),
      .out_tag(out_tag64), .illegal(illegal64));

   typedef struct {
      logic [5:0]  code;
      logic [31:0] a, b, exp;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_lat(input string name, input int act, input int exp);
`ifdef MULDIV_EARLY_OUT_EN
      check(name, 64'((act <= exp) && (act >= ((exp == 1) ? 1 : 3))), 64'd1);
`else
      check(name, 64'(act), 64'(exp));
`endif
   endtask

   // Counts cycles from the request cycle (1 = result in the cycle after accept)
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drive(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
      alucode = c; op1 = a; op2 = b; in_tag = t; in_valid = 1'b1;
   endtask

   task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, output int lat);
      int w;
      @(negedge clk);
      drive(c, a, b, t);
      out_ready = 1'b0;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(lat);
   endtask

   task automatic take;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run64(input logic [5:0] c, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
      @(negedge clk);
      alucode64 = c; a64 = a; b64 = b; tag64 = 5'd21; in_valid64 = 1'b1;
      @(posedge clk); #1;
      in_valid64 = 1'b0;
      lat = 1;
      while (!out_valid64 && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result64;
      check("tag64", 64'(out_tag64), 64'd21);
      @(negedge clk);
      out_ready64 = 1'b1;
      @(posedge clk); #1;
      out_ready64 = 1'b0;
   endtask

   initial begin
      int          lat;
      logic        seen;
      logic [63:0] r64;

      vecs[0]  = '{ALU_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34};
      vecs[1]  = '{ALU_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 1'b0, 34};
      vecs[2]  = '{ALU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34};
      vecs[3]  = '{ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34};
      vecs[4]  = '{ALU_MULH,   32'hFFFFFFFB,   32'd3,        32'hFFFFFFFF, 1'b0, 34};
      vecs[5]  = '{ALU_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0, 34};
      vecs[6]  = '{ALU_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1'b0, 34};
      vecs[7]  = '{ALU_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34};
      vecs[8]  = '{ALU_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        1'b0, 34};
      vecs[9]  = '{ALU_DIVU,   32'd100,        32'd7,        32'd14,       1'b0, 34};
      vecs[10] = '{ALU_REMU,   32'd100,        32'd7,        32'd2,        1'b0, 34};
      vecs[11] = '{ALU_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1'b0, 1};
      vecs[12] = '{ALU_REM,    32'd5,          32'd0,        32'd5,        1'b0, 1};
      vecs[13] = '{ALU_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1'b0, 1};
      vecs[14] = '{ALU_REMU,   32'd5,          32'd0,        32'd5,        1'b0, 1};
      vecs[15] = '{ALU_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
      vecs[16] = '{ALU_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1'b0, 1};
      vecs[17] = '{6'd0,       32'd12,         32'd34,       32'd0,        1'b1, 1};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alucode = '0; op1 = '0; op2 = '0; in_tag = '0;
      flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b0;
      alucode64 = '0; a64 = '0; b64 = '0; tag64 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result",    64'(result),    64'd0);
      check("rst_out_tag",   64'(out_tag),   64'd0);
      check("rst_illegal",   64'(illegal),   64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         run_op(vecs[i].code, vecs[i].a, vecs[i].b, 5'(i), lat);
         check($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].exp));
         check($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(i));
         check($sformatf("vec%0d_illegal", i), 64'(illegal), 64'(vecs[i].ill));
         check_lat($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         take();
      end

      // Backpressure: hold for 10 cycles, then issue on the release edge
      run_op(ALU_MUL, 32'd7, 32'hFFFFFFFD, 5'd9, lat);
      repeat (10) begin
         @(posedge clk); #1;
      end
      check("bp_result",    64'(result),    64'hFFFFFFEB);
      check("bp_out_tag",   64'(out_tag),   64'd9);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      @(negedge clk);
      out_ready = 1'b1;
      drive(ALU_DIVU, 32'd100, 32'd7, 5'd3);
      #1;
      check("bp_release_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      check("bp_reissue_busy", 64'(out_valid), 64'd0);
      wait_out(lat);
      check("bp2_result", 64'(result),  64'd14);
      check("bp2_tag",    64'(out_tag), 64'd3);
      check_lat("bp2_latency", lat, 34);
      take();

      // Flush ten cycles into a DIV, then flush racing a request in IDLE
      @(negedge clk);
      drive(ALU_DIV, 32'hFFFFFFF9, 32'd2, 5'd4);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready",  64'(in_ready),  64'd1);
      @(negedge clk);
      flush = 1'b1;
      drive(ALU_DIVU, 32'd100, 32'd7, 5'd5);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("flush_no_result", 64'(seen), 64'd0);
      run_op(ALU_DIVU, 32'd100, 32'd7, 5'd7, lat);
      check("post_flush_result", 64'(result),  64'd14);
      check("post_flush_tag",    64'(out_tag), 64'd7);
      take();

      // Asynchronous reset in the middle of a multiply
      @(negedge clk);
      drive(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready",  64'(in_ready),  64'd1);
      check("arst_result",    64'(result),    64'd0);
      check("arst_out_tag",   64'(out_tag),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, lat);
      check("post_rst_result", 64'(result), 64'hFFFFFFFE);
      take();

      // 64-bit instance
      run64(ALU_DIVU, 64'hFFFFFFFF_FFFFFFFF, 64'h00000001_00000000, r64, lat);
      check("x64_divu", r64, 64'h00000000_FFFFFFFF);
      check_lat("x64_divu_latency", lat, 66);
      run64(ALU_REMU, 64'hFFFFFFFF_FFFFFFFF, 64'h00000001_00000000, r64, lat);
      check("x64_remu", r64, 64'h00000000_FFFFFFFF);
      run64(ALU_DIV, 64'hFFFFFFFF_FFFFFFF9, 64'd2, r64, lat);
      check("x64_div", r64, 64'hFFFFFFFF_FFFFFFFD);
      run64(ALU_MULHU, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, r64, lat);
      check("x64_mulhu", r64, 64'hFFFFFFFF_FFFFFFFE);
      run64(ALU_DIV, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, r64, lat);
      check("x64_div_ovf", r64, 64'h80000000_00000000);
      check_lat("x64_div_ovf_latency", lat, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
